// File: rtl/xc_malu_multiplier_if.sv
// ============================================================================
//  Module      : xc_malu_multiplier_if
//  Description : Request/response bundle for the MALU shift-add multiplier.
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

interface xc_malu_multiplier_if;
    logic        valid;
    logic        flush;
    logic [31:0] rs1;
    logic [31:0] rs2;
    logic        op_signed_lhs;
    logic        op_signed_rhs;
    logic        busy;
    logic        finished;
    logic [63:0] result;

    modport master (
        output valid, flush, rs1, rs2, op_signed_lhs, op_signed_rhs,
        input  busy, finished, result
    );

    modport slave (
        input  valid, flush, rs1, rs2, op_signed_lhs, op_signed_rhs,
        output busy, finished, result
    );
endinterface

`default_nettype wire

// File: rtl/xc_malu_multiplier.sv
// ============================================================================
//  Module      : xc_malu_multiplier
//  Description : Sequential 32x32->64 shift-add multiplier, 33-cycle latency,
//                with per-operand signedness for mul/mulh/mulhsu/mulhu.
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module xc_malu_multiplier (
    input  wire                    clock,
    input  wire                    reset,
    xc_malu_multiplier_if.slave    bus
);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_RUN  = 2'd1,
        S_FIX  = 2'd2,
        S_DONE = 2'd3
    } state_t;

    localparam logic [4:0] c_LAST_STEP = 5'd31;

    state_t      r_state;
    state_t      w_next_state;
    logic [63:0] r_acc;
    logic [31:0] r_mcand;
    logic [31:0] r_mplier;
    logic        r_neg;
    logic [4:0]  r_counter;
    logic [63:0] r_result;

    logic        w_lhs_neg;
    logic        w_rhs_neg;
    logic [31:0] w_lhs_mag;
    logic [31:0] w_rhs_mag;
    logic [32:0] w_sum;

    // Magnitudes of the operands; 0x80000000 negates to itself, which is the
    // correct unsigned magnitude.
    assign w_lhs_neg = bus.op_signed_lhs & bus.rs1[31];
    assign w_rhs_neg = bus.op_signed_rhs & bus.rs2[31];
    assign w_lhs_mag = w_lhs_neg ? (32'd0 - bus.rs1) : bus.rs1;
    assign w_rhs_mag = w_rhs_neg ? (32'd0 - bus.rs2) : bus.rs2;

    assign w_sum = {1'b0, r_acc[63:32]} + (r_mplier[0] ? {1'b0, r_mcand} : 33'd0);

    always_ff @(posedge clock) begin
        if (reset) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_next_state;
        end
    end

    always_comb begin
        w_next_state = r_state;
        case (r_state)
            S_IDLE: if (bus.valid) w_next_state = S_RUN;
            S_RUN:  if (r_counter == c_LAST_STEP) w_next_state = S_FIX;
            S_FIX:  w_next_state = S_DONE;
            S_DONE: if (!bus.valid) w_next_state = S_IDLE;
            default: w_next_state = S_IDLE;
        endcase
        if (bus.flush) begin
            w_next_state = S_IDLE;
        end
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            r_acc     <= 64'd0;
            r_mcand   <= 32'd0;
            r_mplier  <= 32'd0;
            r_neg     <= 1'b0;
            r_counter <= 5'd0;
            r_result  <= 64'd0;
        end else if (bus.flush) begin
            r_counter <= 5'd0;
            r_result  <= 64'd0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (bus.valid) begin
                        r_mcand   <= w_lhs_mag;
                        r_mplier  <= w_rhs_mag;
                        r_neg     <= w_lhs_neg ^ w_rhs_neg;
                        r_acc     <= 64'd0;
                        r_counter <= 5'd0;
                    end
                end
                S_RUN: begin
                    // Partial sum enters at the top; the 65-bit {sum, acc} shifts right.
                    r_acc     <= {w_sum, r_acc[31:1]};
                    r_mplier  <= r_mplier >> 1;
                    r_counter <= r_counter + 5'd1;
                end
                S_FIX: begin
                    r_result <= r_neg ? (64'd0 - r_acc) : r_acc;
                end
                default: begin
                end
            endcase
        end
    end

    assign bus.busy     = (r_state == S_RUN) || (r_state == S_FIX);
    assign bus.finished = (r_state == S_DONE);
    assign bus.result   = r_result;

endmodule

`default_nettype wire

// File: tb/tb_xc_malu_multiplier.sv
// ============================================================================
//  Module      : tb_xc_malu_multiplier
//  Description : Self-checking bench for xc_malu_multiplier with a reference
//                model, directed literal cases and randomized operands.
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_xc_malu_multiplier;

    logic clock;
    logic reset;
    int   n_checks;
    int   n_errors;
    bit   chk_en;

    xc_malu_multiplier_if bus ();

    xc_malu_multiplier dut (
        .clock (clock),
        .reset (reset),
        .bus   (bus)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    // Reference: the true product of the (optionally sign-extended) operands.
    function automatic logic [63:0] model_mul(input logic [31:0] a, input logic [31:0] b,
                                              input logic sa, input logic sb);
        logic [63:0] xa;
        logic [63:0] xb;
        xa = sa ? {{32{a[31]}}, a} : {32'd0, a};
        xb = sb ? {{32{b[31]}}, b} : {32'd0, b};
        return xa * xb;
    endfunction

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%h, expected 0x%h", name, act, exp);
        end
    endtask

    // Observable behaviour: cycles remaining until completion, done flag, result.
    int          m_left;
    bit          m_fin;
    logic [63:0] m_res;
    logic [63:0] m_pending;

    always @(posedge clock) begin
        if (reset || bus.flush) begin
            m_left = 0;
            m_fin  = 0;
            m_res  = 64'd0;
        end else if (m_fin) begin
            if (!bus.valid) m_fin = 0;
        end else if (m_left > 0) begin
            m_left--;
            if (m_left == 0) begin
                m_fin = 1;
                m_res = m_pending;
            end
        end else if (bus.valid) begin
            m_left    = 33;
            m_pending = model_mul(bus.rs1, bus.rs2, bus.op_signed_lhs, bus.op_signed_rhs);
        end
    end

    always @(negedge clock) begin
        if (chk_en) begin
            check("busy", {63'd0, bus.busy}, {63'd0, (m_left > 0)});
            check("finished", {63'd0, bus.finished}, {63'd0, m_fin});
            check("busy_and_finished", {63'd0, bus.busy & bus.finished}, 64'd0);
            if (m_fin) check("result", bus.result, m_res);
        end
    end

    task automatic run_op(input logic [31:0] a, input logic [31:0] b, input logic sa,
                          input logic sb, input bit use_exp, input logic [63:0] exp,
                          input int hold);
        int lat;
        int bcnt;
        @(negedge clock);
        bus.rs1 = a;
        bus.rs2 = b;
        bus.op_signed_lhs = sa;
        bus.op_signed_rhs = sb;
        bus.valid = 1'b1;
        @(posedge clock);
        #1;
        bcnt = bus.busy ? 1 : 0;
        lat  = 0;
        while (!bus.finished && lat < 60) begin
            @(posedge clock);
            #1;
            lat++;
            if (bus.busy) bcnt++;
        end
        check("latency", 64'(lat), 64'd33);
        check("busy_cycles", 64'(bcnt), 64'd33);
        if (use_exp) check("literal_result", bus.result, exp);
        repeat (hold) @(posedge clock);
        @(negedge clock);
        bus.valid = 1'b0;
        @(posedge clock);
        #1;
        check("finished_drop", {63'd0, bus.finished}, 64'd0);
    endtask

    initial begin
        n_checks = 0;
        n_errors = 0;
        chk_en   = 0;
        reset    = 1'b1;
        bus.valid = 1'b0;
        bus.flush = 1'b0;
        bus.rs1 = 32'd0;
        bus.rs2 = 32'd0;
        bus.op_signed_lhs = 1'b0;
        bus.op_signed_rhs = 1'b0;
        repeat (3) @(posedge clock);
        #1;
        check("reset_busy", {63'd0, bus.busy}, 64'd0);
        check("reset_finished", {63'd0, bus.finished}, 64'd0);
        check("reset_result", bus.result, 64'd0);
        @(negedge clock);
        reset  = 1'b0;
        chk_en = 1;

        // Hand-computed products pin the model.
        run_op(32'hFFFFFFFF, 32'hFFFFFFFF, 0, 0, 1, 64'hFFFFFFFE_00000001, 0);
        run_op(32'hFFFFFFFF, 32'hFFFFFFFF, 1, 1, 1, 64'h00000000_00000001, 0);
        run_op(32'h80000000, 32'h80000000, 1, 1, 1, 64'h40000000_00000000, 0);
        run_op(32'hFFFFFFFE, 32'hFFFFFFFF, 1, 0, 1, 64'hFFFFFFFE_00000002, 0);
        run_op(32'd7, 32'hFFFFFFFD, 1, 1, 1, 64'hFFFFFFFF_FFFFFFEB, 0);
        run_op(32'd0, 32'h80000000, 1, 1, 1, 64'd0, 0);
        run_op(32'h12345678, 32'h9ABCDEF0, 0, 0, 1, 64'h0B00EA4E_242D2080, 5);

        // Flush at counter 10, then restart.
        @(negedge clock);
        bus.rs1 = 32'hDEADBEEF;
        bus.rs2 = 32'h01234567;
        bus.valid = 1'b1;
        @(posedge clock);
        repeat (10) @(posedge clock);
        @(negedge clock);
        bus.flush = 1'b1;
        @(posedge clock);
        #1;
        check("flush_busy", {63'd0, bus.busy}, 64'd0);
        check("flush_finished", {63'd0, bus.finished}, 64'd0);
        check("flush_result", bus.result, 64'd0);
        @(negedge clock);
        bus.flush = 1'b0;
        bus.valid = 1'b0;
        run_op(32'd3, 32'd5, 0, 0, 1, 64'h0F, 0);

        // valid and flush together in IDLE must not start.
        @(negedge clock);
        bus.valid = 1'b1;
        bus.flush = 1'b1;
        @(posedge clock);
        #1;
        check("valid_flush_idle", {63'd0, bus.busy}, 64'd0);
        @(negedge clock);
        bus.valid = 1'b0;
        bus.flush = 1'b0;

        // Reset mid-RUN.
        @(negedge clock);
        bus.rs1 = 32'hFFFF0000;
        bus.rs2 = 32'h0000FFFF;
        bus.valid = 1'b1;
        @(posedge clock);
        repeat (15) @(posedge clock);
        @(negedge clock);
        reset = 1'b1;
        @(posedge clock);
        #1;
        check("rst_run_busy", {63'd0, bus.busy}, 64'd0);
        check("rst_run_finished", {63'd0, bus.finished}, 64'd0);
        check("rst_run_result", bus.result, 64'd0);
        @(negedge clock);
        reset = 1'b0;
        bus.valid = 1'b0;

        // Randomized operands with occasional corner values.
        for (int i = 0; i < 30; i++) begin
            logic [31:0] a;
            logic [31:0] b;
            a = $urandom;
            b = $urandom;
            case ($urandom_range(0, 5))
                0: a = 32'h80000000;
                1: b = 32'hFFFFFFFF;
                2: a = 32'd0;
                default: ;
            endcase
            run_op(a, b, 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), 0, 64'd0,
                   $urandom_range(0, 2));
        end

        repeat (2) @(posedge clock);
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule

`default_nettype wire

// File: doc/xc_malu_multiplier.md
# xc_malu_multiplier

Sequential 32x32 -> 64-bit shift-add multiplier for the multi-cycle ALU (MALU). It is the multiply counterpart to the MALU restoring divider. It serves `mul`, `mulh`, `mulhsu` and `mulhu` through per-operand signedness controls. The block owns its own accumulator, operand and counter state, and reports completion with a held `finished` flag.

## Interface
Parameters: none.
- `clock` in 1: sole clock; all state updates on rising edge.
- `reset` in 1: synchronous, active-high reset.
- `valid` in 1: request; rs1/rs2/sign controls must be stable while high.
- `flush` in 1: abandon current operation.
- `rs1` in 32: multiplicand.
- `rs2` in 32: multiplier.
- `op_signed_lhs` in 1: treat rs1 as two's complement.
- `op_signed_rhs` in 1: treat rs2 as two's complement.
- `busy` out 1: high in RUN or FIX.
- `finished` out 1: high in DONE.
- `result` out 64: product; valid while `finished`.

## Operation
- States: IDLE, RUN, FIX, DONE.
- IDLE:
  - `valid && !flush` -> RUN.
  - Load `mcand = |rs1|` and `mplier = |rs2|`. Magnitude is applied only when the matching signed flag is set and bit 31 = 1. 0x80000000 magnitude = 0x80000000 unsigned.
  - Load `neg = (op_signed_lhs & rs1[31]) ^ (op_signed_rhs & rs2[31])`, `acc = 0`, `counter = 0`.
- RUN, one step per cycle:
  - `sum[32:0] = acc[63:32] + (mplier[0] ? mcand : 0)`.
  - `acc <= {sum, acc[31:1]}`, i.e. logical shift right of the 65-bit sum/acc concatenation.
  - `mplier <= mplier >> 1`, `counter <= counter + 1`.
  - When `counter == 31`, go to FIX after that step. RUN is exactly 32 cycles.
- FIX: `result <= neg ? -acc : acc`, 64-bit two's complement. Go to DONE.
- DONE:
  - `finished = 1`; `result` is held.
  - Stay while `valid` is high. `valid` low -> IDLE.
  - A new operation requires `valid` to be low for at least one cycle after DONE.
- `flush` in any state -> IDLE on the next edge and `result <= 0`. Flush has priority over `valid` in IDLE.
- `reset` has priority over `flush`.
- No early termination on zero operands; latency is data-independent.

## Timing
- Reset values: state IDLE, `busy` 0, `finished` 0, `result` 0, `counter` 0, `acc` 0.
- Edge E samples `valid` in IDLE:
  - `busy` is high from E+1 through E+33.
  - `finished` rises after edge E+33, giving 33-cycle latency.
  - `result` is stable from E+33.
- `busy` and `finished` are never high together.
- Flush sampled at edge F: `busy`/`finished` are low after F, and the next start is possible at F+1 if `valid` is high and `flush` is low.
- Reset mid-RUN: identical to the reset values above, with no partial result visible.
- Inputs are sampled only at the IDLE->RUN edge. Changes during RUN do not affect the result.

## Test plan
- Unsigned 0xFFFFFFFF x 0xFFFFFFFF, both signed flags 0 -> `result` = 0xFFFFFFFE_00000001. `finished` asserts 33 cycles after the accepting edge. `busy` is high for exactly 33 cycles.
- Signed/signed: rs1 = rs2 = 0xFFFFFFFF -> 0x00000000_00000001. rs1 = rs2 = 0x80000000 -> 0x40000000_00000000.
- Signed x unsigned (mulhsu): rs1 = 0xFFFFFFFE (lhs signed), rs2 = 0xFFFFFFFF -> 0xFFFFFFFE_00000002. Signed 7 x -3 -> 0xFFFFFFFF_FFFFFFEB.
- Zero operand: 0 x 0x80000000, both signed -> 0 (neg = 1, but -0 = 0).
- Flush at RUN counter 10 -> IDLE next cycle with `busy` 0, `finished` 0, `result` 0. A restart with 3 x 5 -> 0x0F after 33 cycles.
- Hold and handshake:
  - `valid` held high for 5 cycles after DONE -> `finished` and `result` stay stable with no restart.
  - `valid` dropped -> IDLE.
  - `reset` asserted mid-RUN -> all outputs 0 next cycle.
  - `valid` and `flush` asserted together in IDLE -> no start.
